// File: rtl/noc_rx_mailbox.sv
// Receive mailbox: accepts router packets addressed to NODE_ID into a FIFO and presents the head entry to the MEM stage.
// Optional `RX_DROP_CNT_EN adds a saturating drop_cnt output that counts consumed misaddressed packets.
module noc_rx_mailbox #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 2,
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       noc_valid_in,
    output logic                       noc_ready_out,
    input  logic [ADDR_W-1:0]          noc_dest_in,
    input  logic [ADDR_W-1:0]          noc_src_in,
    input  logic [DATA_W-1:0]          noc_data_in,
    input  logic                       rx_pop,
    output logic                       rx_valid,
    output logic [DATA_W-1:0]          rx_data,
    output logic [ADDR_W-1:0]          rx_src,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic                       rx_underflow
`ifdef RX_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic             accept, addr_match, store, pop;
    logic [ENT_W-1:0] head;

    assign noc_ready_out = (count_q != CNT_W'(DEPTH));
    assign rx_valid      = (count_q != '0);
    assign accept        = noc_valid_in && noc_ready_out;
    assign addr_match    = (noc_dest_in == ADDR_W'(NODE_ID));
    assign store         = accept && addr_match;
    assign pop           = rx_pop && rx_valid;
    assign head          = mem_q[rd_ptr_q];

    // Stale storage behind an empty FIFO is masked so the outputs read zero.
    assign rx_data      = rx_valid ? head[DATA_W-1:0] : '0;
    assign rx_src       = rx_valid ? head[ENT_W-1:DATA_W] : '0;
    assign rx_count     = count_q;
    assign rx_underflow = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = rx_pop && !rx_valid;
        if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: the cleared pointers and count invalidate every entry.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= {noc_src_in, noc_data_in};
    end

`ifdef RX_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !addr_match && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_rx_mailbox.sv
module tb_noc_rx_mailbox;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 2;
    localparam int NODE_ID = 0;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                noc_valid_in;
    logic                noc_ready_out;
    logic [ADDR_W-1:0]   noc_dest_in;
    logic [ADDR_W-1:0]   noc_src_in;
    logic [DATA_W-1:0]   noc_data_in;
    logic                rx_pop;
    logic                rx_valid;
    logic [DATA_W-1:0]   rx_data;
    logic [ADDR_W-1:0]   rx_src;
    logic [CNT_W-1:0]    rx_count;
    logic                rx_underflow;
`ifdef RX_DROP_CNT_EN
    logic [15:0]         drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of {src,data} plus expected pulse and drop count.
    logic [ADDR_W+DATA_W-1:0] model_q [$];
    logic                     exp_uf;
    int                       exp_drop;

    noc_rx_mailbox #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NODE_ID(NODE_ID), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .noc_valid_in(noc_valid_in), .noc_ready_out(noc_ready_out),
        .noc_dest_in(noc_dest_in), .noc_src_in(noc_src_in), .noc_data_in(noc_data_in),
        .rx_pop(rx_pop), .rx_valid(rx_valid), .rx_data(rx_data), .rx_src(rx_src),
        .rx_count(rx_count), .rx_underflow(rx_underflow)
`ifdef RX_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = model_q.size();
        chk("rx_count", 64'(rx_count), 64'(n));
        chk("rx_valid", 64'(rx_valid), 64'(n != 0));
        chk("ready", 64'(noc_ready_out), 64'(n != DEPTH));
        chk("rx_data", 64'(rx_data), (n != 0) ? 64'(model_q[0][DATA_W-1:0]) : 64'd0);
        chk("rx_src", 64'(rx_src), (n != 0) ? 64'(model_q[0][ADDR_W+DATA_W-1:DATA_W]) : 64'd0);
        chk("rx_underflow", 64'(rx_underflow), 64'(exp_uf));
`ifdef RX_DROP_CNT_EN
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif
    endtask

    // Drive one cycle of inputs at negedge, advance the model, check after the edge.
    task automatic do_cycle(input logic v, input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] s,
                            input logic [DATA_W-1:0] x, input logic p, input logic r);
        int  n;
        logic acc;
        rst_n = r; noc_valid_in = v; noc_dest_in = d; noc_src_in = s; noc_data_in = x; rx_pop = p;
        n = model_q.size();
        if (!r) begin
            model_q.delete();
            exp_uf   = 1'b0;
            exp_drop = 0;
        end else begin
            acc    = v && (n < DEPTH);
            exp_uf = p && (n == 0);
            if (p && n > 0) void'(model_q.pop_front());
            if (acc && d == ADDR_W'(NODE_ID)) model_q.push_back({s, x});
            if (acc && d != ADDR_W'(NODE_ID) && exp_drop < 65535) exp_drop++;
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    logic [ADDR_W-1:0] me, other;
    logic              p_vld, p_pop;
    logic [ADDR_W-1:0] p_dest, p_src;
    logic [DATA_W-1:0] p_data;

    initial begin
        me    = ADDR_W'(NODE_ID);
        other = ADDR_W'(NODE_ID + 1);
        rst_n = 1'b0; noc_valid_in = 1'b1; noc_dest_in = me; noc_src_in = '0;
        noc_data_in = 32'h55; rx_pop = 1'b0;
        model_q.delete(); exp_uf = 1'b0; exp_drop = 0;
        @(negedge clk);

        // Reset while the router is presenting a packet: nothing stored.
        do_cycle(1, me, 2'd1, 32'h55, 0, 0);
        chk("reset_count", 64'(rx_count), 64'd0);
        chk("reset_ready", 64'(noc_ready_out), 64'd1);

        // Single packet, first-word-fall-through.
        do_cycle(1, me, 2'd2, 32'hDEADBEEF, 0, 1);
        chk("single_data", 64'(rx_data), 64'hDEADBEEF);
        chk("single_src", 64'(rx_src), 64'd2);
        do_cycle(0, me, 2'd0, 32'h0, 1, 1);

        // Fill to DEPTH, hold the 5th, pop once, then the 5th goes in across the wrap.
        for (int i = 1; i <= 4; i++) do_cycle(1, me, 2'(i), 32'(i), 0, 1);
        chk("full_ready", 64'(noc_ready_out), 64'd0);
        do_cycle(1, me, 2'd1, 32'd5, 0, 1);
        do_cycle(1, me, 2'd1, 32'd5, 1, 1);
        chk("full_pop_head", 64'(rx_data), 64'd2);
        do_cycle(1, me, 2'd1, 32'd5, 0, 1);
        chk("fifth_count", 64'(rx_count), 64'd4);
        for (int i = 2; i <= 5; i++) begin
            chk("drain_order", 64'(rx_data), 64'(i));
            do_cycle(0, me, 2'd0, 32'd0, 1, 1);
        end

        // Misaddressed packet is consumed, not stored.
        do_cycle(1, other, 2'd3, 32'h1, 0, 1);
        chk("misaddr_count", 64'(rx_count), 64'd0);
`ifdef RX_DROP_CNT_EN
        chk("misaddr_drop", 64'(drop_cnt), 64'd1);
`endif

        // Simultaneous push/pop at count 2.
        do_cycle(1, me, 2'd1, 32'hA, 0, 1);
        do_cycle(1, me, 2'd1, 32'hB, 0, 1);
        do_cycle(1, me, 2'd1, 32'hC, 1, 1);
        chk("pushpop_count", 64'(rx_count), 64'd2);
        chk("pushpop_head", 64'(rx_data), 64'hB);

        // Pop on empty: one-cycle underflow pulse.
        do_cycle(0, me, 2'd0, 32'd0, 0, 0);
        do_cycle(0, me, 2'd0, 32'd0, 1, 1);
        chk("uf_pulse", 64'(rx_underflow), 64'd1);
        do_cycle(0, me, 2'd0, 32'd0, 0, 1);
        chk("uf_clear", 64'(rx_underflow), 64'd0);

        // Store+pop on empty: pop is an underflow, the packet is still stored.
        do_cycle(1, me, 2'd3, 32'h77, 1, 1);
        chk("empty_pushpop_count", 64'(rx_count), 64'd1);

        // Randomized traffic; the router holds a packet stable until accepted.
        p_vld = 1'b0; p_dest = me; p_src = '0; p_data = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!(p_vld && model_q.size() == DEPTH)) begin
                p_vld  = ($urandom_range(0, 3) != 0);
                p_dest = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : me;
                p_src  = ADDR_W'($urandom);
                p_data = $urandom;
            end
            p_pop = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                do_cycle(p_vld, p_dest, p_src, p_data, p_pop, 0);
                p_vld = 1'b0;
            end else begin
                do_cycle(p_vld, p_dest, p_src, p_data, p_pop, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
